lsu_stage: RTL and testbench

Load/store stage between execute and writeback. Accepts one instruction per cycle from EX and, for loads and stores, runs a req/ack data-bus transaction. Aligns and sign/zero-extends load data, then presents a registered single-cycle GPR write (`rd_we_o`/`rd_wa_o`/`rd_wd_o`) to the writeback register file. Stalls the upstream pipeline while a bus access is outstanding.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_load_align.sv | 49 ++++
 rtl/lsu_stage.sv | 170 +++++++++++++++++
 tb/tb_lsu_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store stage.
package lsu_pkg;

    localparam int XLEN         = 32;
    localparam int REG_NUM_LOG2 = 5;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } memop_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    function automatic logic is_load(input memop_t op);
        case (op)
            LB, LH, LW, LBU, LHU: is_load = 1'b1;
            default:              is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input memop_t op);
        case (op)
            SB, SH, SW: is_store = 1'b1;
            default:    is_store = 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input memop_t op, input logic [1:0] off);
        case (op)
            LH, LHU, SH: is_misaligned = off[0];
            LW, SW:      is_misaligned = (off != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input memop_t op, input logic [1:0] off);
        case (op)
            LB, LBU, SB: byte_en = 4'b0001 << off;
            LH, LHU, SH: byte_en = 4'b0011 << off;
            LW, SW:      byte_en = 4'b1111;
            default:     byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module lsu_load_align #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [3:0]      op_i,
    output logic [XLEN-1:0] data_o
);
    import lsu_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    memop_t      op_s;

    assign op_s = memop_t'(op_i);

    // Pick the byte and halfword lanes named by the address offset.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (off_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        case (off_i[1])
            1'b0:    half_s = rdata_i[15:0];
            1'b1:    half_s = rdata_i[31:16];
            default: half_s = 16'h0000;
        endcase
    end

    // Extend the selected lane according to the load flavour.
    always_comb begin
        data_o = {XLEN{1'b0}};
        case (op_s)
            LB:      data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            LBU:     data_o = {{(XLEN-8){1'b0}}, byte_s};
            LH:      data_o = {{(XLEN-16){half_s[15]}}, half_s};
            LHU:     data_o = {{(XLEN-16){1'b0}}, half_s};
            LW:      data_o = rdata_i;
            default: data_o = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: runs one req/ack bus access per memory op and
// produces a registered single-cycle GPR write for writeback.
module lsu_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    input  logic [3:0]      in_memop_i,
    input  logic [XLEN-1:0] in_addr_i,
    input  logic [XLEN-1:0] in_sdata_i,
    input  logic            in_rd_we_i,
    input  logic [4:0]      in_rd_wa_i,
    output logic            stall_o,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [3:0]      dbus_be_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    input  logic            dbus_ack_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    output logic            misalign_o,
    output logic            rd_we_o,
    output logic [4:0]      rd_wa_o,
    output logic [XLEN-1:0] rd_wd_o
);
    import lsu_pkg::*;

    memop_t                  in_op_s;
    logic [XLEN-1:0]         load_data_s;

    state_t                  state_q, state_d;
    memop_t                  op_q, op_d;
    logic [1:0]              off_q, off_d;
    logic                    ld_we_q, ld_we_d;
    logic [REG_NUM_LOG2-1:0] ld_wa_q, ld_wa_d;
    logic                    dbus_we_q, dbus_we_d;
    logic [XLEN-1:0]         dbus_addr_q, dbus_addr_d;
    logic [3:0]              dbus_be_q, dbus_be_d;
    logic [XLEN-1:0]         dbus_wdata_q, dbus_wdata_d;
    logic                    rd_we_q, rd_we_d;
    logic [REG_NUM_LOG2-1:0] rd_wa_q, rd_wa_d;
    logic [XLEN-1:0]         rd_wd_q, rd_wd_d;
    logic                    misalign_q, misalign_d;

    assign in_op_s = memop_t'(in_memop_i);

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata_i (dbus_rdata_i),
        .off_i   (off_q),
        .op_i    (op_q),
        .data_o  (load_data_s)
    );

    // Next-state and output logic: accept in IDLE, wait for ack in BUS.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        ld_we_d      = ld_we_q;
        ld_wa_d      = ld_wa_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_be_d    = dbus_be_q;
        dbus_wdata_d = dbus_wdata_q;
        rd_we_d      = 1'b0;
        rd_wa_d      = rd_wa_q;
        rd_wd_d      = rd_wd_q;
        misalign_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    if (in_op_s == MEM_NONE) begin
                        rd_we_d = in_rd_we_i;
                        rd_wa_d = in_rd_wa_i;
                        rd_wd_d = in_addr_i;
                    end else if (is_load(in_op_s) || is_store(in_op_s)) begin
                        if (is_misaligned(in_op_s, in_addr_i[1:0])) begin
                            misalign_d = 1'b1;
                        end else begin
                            state_d     = BUS;
                            op_d        = in_op_s;
                            off_d       = in_addr_i[1:0];
                            ld_we_d     = in_rd_we_i;
                            ld_wa_d     = in_rd_wa_i;
                            dbus_we_d   = is_store(in_op_s);
                            dbus_addr_d = {in_addr_i[XLEN-1:2], 2'b00};
                            dbus_be_d   = byte_en(in_op_s, in_addr_i[1:0]);
                            case (in_op_s)
                                SB:      dbus_wdata_d = {(XLEN/8){in_sdata_i[7:0]}};
                                SH:      dbus_wdata_d = {(XLEN/16){in_sdata_i[15:0]}};
                                SW:      dbus_wdata_d = in_sdata_i;
                                default: dbus_wdata_d = {XLEN{1'b0}};
                            endcase
                        end
                    end else begin
                        // Undefined op encodings retire silently.
                        rd_we_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (dbus_ack_i) begin
                    state_d      = IDLE;
                    dbus_we_d    = 1'b0;
                    dbus_addr_d  = {XLEN{1'b0}};
                    dbus_be_d    = 4'b0000;
                    dbus_wdata_d = {XLEN{1'b0}};
                    if (is_load(op_q)) begin
                        rd_we_d = ld_we_q;
                        rd_wa_d = ld_wa_q;
                        rd_wd_d = load_data_s;
                    end else begin
                        rd_we_d = 1'b0;
                    end
                end else begin
                    state_d = BUS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched-op and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            op_q         <= MEM_NONE;
            off_q        <= 2'b00;
            ld_we_q      <= 1'b0;
            ld_wa_q      <= 5'd0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= {XLEN{1'b0}};
            dbus_be_q    <= 4'b0000;
            dbus_wdata_q <= {XLEN{1'b0}};
            rd_we_q      <= 1'b0;
            rd_wa_q      <= 5'd0;
            rd_wd_q      <= {XLEN{1'b0}};
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            ld_we_q      <= ld_we_d;
            ld_wa_q      <= ld_wa_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_be_q    <= dbus_be_d;
            dbus_wdata_q <= dbus_wdata_d;
            rd_we_q      <= rd_we_d;
            rd_wa_q      <= rd_wa_d;
            rd_wd_q      <= rd_wd_d;
            misalign_q   <= misalign_d;
        end
    end

    assign stall_o      = (state_q == BUS);
    assign dbus_req_o   = (state_q == BUS);
    assign dbus_we_o    = dbus_we_q;
    assign dbus_addr_o  = dbus_addr_q;
    assign dbus_be_o    = dbus_be_q;
    assign dbus_wdata_o = dbus_wdata_q;
    assign rd_we_o      = rd_we_q;
    assign rd_wa_o      = rd_wa_q;
    assign rd_wd_o      = rd_wd_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_lsu_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    memop_t      in_op = MEM_NONE;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_sdata = 32'h0;
    logic        in_rd_we = 1'b0;
    logic [4:0]  in_rd_wa = 5'd0;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = 32'h0;

    logic        stall_o, dbus_req_o, dbus_we_o, misalign_o, rd_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, rd_wd_o;
    logic [3:0]  dbus_be_o;
    logic [4:0]  rd_wa_o;

    int n_vec  = 0;
    int n_fail = 0;

    lsu_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_memop_i   (in_op),
        .in_addr_i    (in_addr),
        .in_sdata_i   (in_sdata),
        .in_rd_we_i   (in_rd_we),
        .in_rd_wa_i   (in_rd_wa),
        .stall_o      (stall_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_be_o    (dbus_be_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_ack_i   (dbus_ack),
        .dbus_rdata_i (dbus_rdata),
        .misalign_o   (misalign_o),
        .rd_we_o      (rd_we_o),
        .rd_wa_o      (rd_wa_o),
        .rd_wd_o      (rd_wd_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input memop_t op);
        if (op inside {LB, LBU, SB}) return 1;
        else if (op inside {LH, LHU, SH}) return 2;
        else return 4;
    endfunction

    function automatic logic op_store(input memop_t op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic [31:0] model_load(input memop_t op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        case (op)
            LB:      return 32'($signed(v[7:0]));
            LBU:     return v & 32'h0000_00FF;
            LH:      return 32'($signed(v[15:0]));
            LHU:     return v & 32'h0000_FFFF;
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input memop_t op, input logic [31:0] sd);
        case (op_size(op))
            1:       return (sd & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (sd & 32'h0000_FFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    bit          m_pend;
    memop_t      m_op;
    logic [31:0] m_addr, m_sdata;
    logic        m_rdwe;
    logic [4:0]  m_rdwa;
    logic        e_we, e_mis;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;

    // Transaction model: one outstanding access, results one cycle after completion.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= 1'b0;
            e_we   <= 1'b0;
            e_mis  <= 1'b0;
            e_wa   <= 5'd0;
            e_wd   <= 32'h0;
        end else begin
            e_we  <= 1'b0;
            e_mis <= 1'b0;
            if (m_pend) begin
                if (dbus_ack) begin
                    m_pend <= 1'b0;
                    if (!op_store(m_op)) begin
                        e_we <= m_rdwe;
                        e_wa <= m_rdwa;
                        e_wd <= model_load(m_op, m_addr, dbus_rdata);
                    end
                end
            end else if (in_valid) begin
                if (in_op == MEM_NONE) begin
                    e_we <= in_rd_we;
                    e_wa <= in_rd_wa;
                    e_wd <= in_addr;
                end else if ((in_addr % op_size(in_op)) != 0) begin
                    e_mis <= 1'b1;
                end else begin
                    m_pend  <= 1'b1;
                    m_op    <= in_op;
                    m_addr  <= in_addr;
                    m_sdata <= in_sdata;
                    m_rdwe  <= in_rd_we;
                    m_rdwa  <= in_rd_wa;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        check("stall", 32'(stall_o), 32'(m_pend));
        check("dbus_req", 32'(dbus_req_o), 32'(m_pend));
        if (m_pend) begin
            check("dbus_addr", dbus_addr_o, m_addr & 32'hFFFF_FFFC);
            check("dbus_be", 32'(dbus_be_o), ((32'd1 << op_size(m_op)) - 32'd1) << (m_addr % 4));
            check("dbus_we", 32'(dbus_we_o), 32'(op_store(m_op)));
            if (op_store(m_op)) check("dbus_wdata", dbus_wdata_o, model_wdata(m_op, m_sdata));
        end
        if (rst) begin
            check("rst_addr", dbus_addr_o, 32'h0);
            check("rst_be", 32'(dbus_be_o), 32'h0);
            check("rst_wdata", dbus_wdata_o, 32'h0);
            check("rst_we", 32'(dbus_we_o), 32'h0);
            check("rst_wa", 32'(rd_wa_o), 32'h0);
            check("rst_wd", rd_wd_o, 32'h0);
        end
        check("rd_we", 32'(rd_we_o), 32'(e_we));
        check("misalign", 32'(misalign_o), 32'(e_mis));
        if (e_we) begin
            check("rd_wa", 32'(rd_wa_o), 32'(e_wa));
            check("rd_wd", rd_wd_o, e_wd);
        end
    end

    // ---------------- stimulus ----------------
    int          stalls;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    // Presents a memory op, acks it after 'waits' wait cycles, returns in cycle A+1.
    task automatic mem_op(input memop_t op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input int waits, input logic [31:0] rdata);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_sdata = sdata;
        in_rd_we = !op_store(op);
        in_rd_wa = rd;
        @(negedge clk);
        in_valid  = 1'b0;
        cap_addr  = dbus_addr_o;
        cap_be    = dbus_be_o;
        cap_wdata = dbus_wdata_o;
        cap_we    = dbus_we_o;
        stalls    = 0;
        for (int w = 0; w <= waits; w++) begin
            if (w > 0) @(negedge clk);
            if (stall_o) stalls++;
            if (w == waits) begin
                dbus_ack   = 1'b1;
                dbus_rdata = rdata;
            end
        end
        @(negedge clk);
        dbus_ack   = 1'b0;
        dbus_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic alu_op(input logic [31:0] val, input logic we, input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = MEM_NONE;
        in_addr  = val;
        in_rd_we = we;
        in_rd_wa = rd;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_req", 32'(dbus_req_o), 32'h0);
        check("reset_stall", 32'(stall_o), 32'h0);
        check("reset_rd_we", 32'(rd_we_o), 32'h0);
        check("reset_misalign", 32'(misalign_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // ALU passthrough
        alu_op(32'h1234_5678, 1'b1, 5'd5);
        check("alu_we", 32'(rd_we_o), 32'h1);
        check("alu_wa", 32'(rd_wa_o), 32'd5);
        check("alu_wd", rd_wd_o, 32'h1234_5678);
        check("alu_noreq", 32'(dbus_req_o), 32'h0);
        alu_op(32'h0000_0777, 1'b0, 5'd6);
        check("alu_nowe", 32'(rd_we_o), 32'h0);

        // LB sign extension, 3 wait cycles
        mem_op(LB, 32'h0000_0103, 32'h0, 5'd3, 3, 32'h80FF_FF00);
        check("lb_be", 32'(cap_be), 32'h8);
        check("lb_stall_cycles", 32'(stalls), 32'd4);
        check("lb_we", 32'(rd_we_o), 32'h1);
        check("lb_wd", rd_wd_o, 32'hFFFF_FF80);
        check("lb_stall_done", 32'(stall_o), 32'h0);
        mem_op(LBU, 32'h0000_0103, 32'h0, 5'd4, 3, 32'h80FF_FF00);
        check("lbu_wd", rd_wd_o, 32'h0000_0080);

        // SH upper half
        mem_op(SH, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0, 1, 32'h0);
        check("sh_addr", cap_addr, 32'h0000_0200);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh_we", 32'(cap_we), 32'h1);
        check("sh_nowrite", 32'(rd_we_o), 32'h0);

        // SB, LH, LHU, SW lane variants
        mem_op(SB, 32'h0000_0301, 32'h1234_5678, 5'd0, 0, 32'h0);
        check("sb_be", 32'(cap_be), 32'h2);
        check("sb_wdata", cap_wdata, 32'h7878_7878);
        mem_op(LH, 32'h0000_0402, 32'h0, 5'd10, 2, 32'h8001_7FFF);
        check("lh_wd", rd_wd_o, 32'hFFFF_8001);
        mem_op(LHU, 32'h0000_0402, 32'h0, 5'd11, 0, 32'h8001_7FFF);
        check("lhu_wd", rd_wd_o, 32'h0000_8001);
        mem_op(SW, 32'h0000_0500, 32'hCAFE_F00D, 5'd0, 0, 32'h0);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_wdata", cap_wdata, 32'hCAFE_F00D);

        // Misaligned LW, next instruction accepted at T+1
        in_valid = 1'b1;
        in_op    = LW;
        in_addr  = 32'h0000_0101;
        in_rd_we = 1'b1;
        in_rd_wa = 5'd8;
        @(negedge clk);
        check("mis_pulse", 32'(misalign_o), 32'h1);
        check("mis_noreq", 32'(dbus_req_o), 32'h0);
        check("mis_nowe", 32'(rd_we_o), 32'h0);
        check("mis_nostall", 32'(stall_o), 32'h0);
        alu_op(32'h0000_0ABC, 1'b1, 5'd7);
        check("mis_next_wd", rd_wd_o, 32'h0000_0ABC);
        check("mis_pulse_end", 32'(misalign_o), 32'h0);
        in_op   = LH;
        in_addr = 32'h0000_0205;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mis_lh_pulse", 32'(misalign_o), 32'h1);

        // Back-to-back zero-wait LW
        mem_op(LW, 32'h0000_0010, 32'h0, 5'd12, 0, 32'h0000_0011);
        check("b2b_stall1", 32'(stalls), 32'd1);
        check("b2b_wd1", rd_wd_o, 32'h0000_0011);
        mem_op(LW, 32'h0000_0014, 32'h0, 5'd13, 0, 32'h0000_0022);
        check("b2b_stall2", 32'(stalls), 32'd1);
        check("b2b_wd2", rd_wd_o, 32'h0000_0022);
        check("b2b_wa2", 32'(rd_wa_o), 32'd13);

        // Reset mid-BUS
        in_valid = 1'b1;
        in_op    = LW;
        in_addr  = 32'h0000_0020;
        in_rd_we = 1'b1;
        in_rd_wa = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_req_before", 32'(dbus_req_o), 32'h1);
        #2 rst = 1'b1;
        #1 check("rst_req_drop", 32'(dbus_req_o), 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h5555_5555;
        @(negedge clk);
        dbus_ack = 1'b0;
        check("rst_nowrite1", 32'(rd_we_o), 32'h0);
        @(negedge clk);
        check("rst_nowrite2", 32'(rd_we_o), 32'h0);
        check("rst_idle", 32'(stall_o), 32'h0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
